// File: rtl/ip_stream_packer.sv
// Packs a narrow word stream into 128-bit beats with byte keep and last flag.
// One completed beat may wait in the output register and one more in the accumulator.
module ip_stream_packer #(
    parameter int DIN_W = 32
) (
    input  logic              m_axis_mm2s_aclk,
    input  logic              m_axis_mm2s_aresetn,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              din_last,
    output logic [127:0]      dout,
    output logic              valid,
    input  logic              ready,
    output logic [15:0]       keep,
    output logic              last,
    output logic [31:0]       beat_cnt,
    output logic [31:0]       pkt_cnt
);

    localparam int LANES  = 128 / DIN_W;
    localparam int LKEEP  = DIN_W / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [127:0]      acc_reg;
    logic [LANE_W-1:0] lane_reg;
    logic              pend_reg;
    logic [15:0]       pend_keep_reg;
    logic              pend_last_reg;
    logic [127:0]      dout_reg;
    logic [15:0]       keep_reg;
    logic              last_reg;
    logic              valid_reg;
    logic [31:0]       beat_cnt_reg;
    logic [31:0]       pkt_cnt_reg;

    logic [127:0]      merged_beat;
    logic [15:0]       merged_keep;
    logic              in_xfer;
    logic              out_xfer;
    logic              out_free;
    logic              beat_done;

    assign in_xfer   = din_valid && !pend_reg;
    assign out_xfer  = valid_reg && ready;
    assign out_free  = !valid_reg || ready;
    assign beat_done = (lane_reg == LAST_LANE) || din_last;

    // Current word goes into its lane; lanes above it are forced to zero.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [LANE_W-1:0] IDX = LANE_W'(gi);
            assign merged_beat[gi*DIN_W +: DIN_W] =
                (lane_reg == IDX) ? din :
                (IDX < lane_reg)  ? acc_reg[gi*DIN_W +: DIN_W] : '0;
            assign merged_keep[gi*LKEEP +: LKEEP] = (IDX <= lane_reg) ? '1 : '0;
        end
    endgenerate

    always_ff @(posedge m_axis_mm2s_aclk or negedge m_axis_mm2s_aresetn) begin
        if (!m_axis_mm2s_aresetn) begin
            acc_reg       <= '0;
            lane_reg      <= '0;
            pend_reg      <= 1'b0;
            pend_keep_reg <= '0;
            pend_last_reg <= 1'b0;
            dout_reg      <= '0;
            keep_reg      <= '0;
            last_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            beat_cnt_reg  <= '0;
            pkt_cnt_reg   <= '0;
        end else begin
            if (out_xfer) begin
                beat_cnt_reg <= beat_cnt_reg + 32'd1;
                if (last_reg)
                    pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
            end

            if (pend_reg) begin
                // Input is stalled; only the held beat can move forward.
                if (out_free) begin
                    dout_reg  <= acc_reg;
                    keep_reg  <= pend_keep_reg;
                    last_reg  <= pend_last_reg;
                    valid_reg <= 1'b1;
                    pend_reg  <= 1'b0;
                    lane_reg  <= '0;
                    acc_reg   <= '0;
                end
            end else if (in_xfer && beat_done) begin
                if (out_free) begin
                    dout_reg  <= merged_beat;
                    keep_reg  <= merged_keep;
                    last_reg  <= din_last;
                    valid_reg <= 1'b1;
                    lane_reg  <= '0;
                    acc_reg   <= '0;
                end else begin
                    acc_reg       <= merged_beat;
                    pend_keep_reg <= merged_keep;
                    pend_last_reg <= din_last;
                    pend_reg      <= 1'b1;
                    lane_reg      <= '0;
                end
            end else begin
                if (in_xfer) begin
                    acc_reg  <= merged_beat;
                    lane_reg <= lane_reg + LANE_W'(1);
                end
                if (out_xfer)
                    valid_reg <= 1'b0;
            end
        end
    end

    assign din_ready = !pend_reg;
    assign dout      = dout_reg;
    assign keep      = keep_reg;
    assign last      = last_reg;
    assign valid     = valid_reg;
    assign beat_cnt  = beat_cnt_reg;
    assign pkt_cnt   = pkt_cnt_reg;

endmodule

// File: tb/tb_ip_stream_packer.sv
// Self-checking bench: directed and random packets against a beat-level reference model.
module tb_ip_stream_packer;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    logic         clk;
    logic         rst_n;
    logic [31:0]  din;
    logic         din_valid;
    logic         din_ready;
    logic         din_last;
    logic [127:0] dout;
    logic         valid;
    logic         ready;
    logic [15:0]  keep;
    logic         last;
    logic [31:0]  beat_cnt;
    logic [31:0]  pkt_cnt;

    logic [7:0]   b_din;
    logic         b_din_valid;
    logic         b_din_ready;
    logic         b_din_last;
    logic [127:0] b_dout;
    logic         b_valid;
    logic         b_ready;
    logic [15:0]  b_keep;
    logic         b_last;
    logic [31:0]  b_beat_cnt;
    logic [31:0]  b_pkt_cnt;

    int checks = 0;
    int errors = 0;
    int gen_beats = 0;
    int gen_pkts = 0;
    int accepted = 0;
    int cyc = 0;

    logic [32:0] in_q[$];
    beat_t       exp_q[$];

    logic         prev_hold;
    logic [127:0] prev_dout;
    logic [15:0]  prev_keep;
    logic         prev_last;

    ip_stream_packer #(.DIN_W(32)) dut (
        .m_axis_mm2s_aclk    (clk),
        .m_axis_mm2s_aresetn (rst_n),
        .din                 (din),
        .din_valid           (din_valid),
        .din_ready           (din_ready),
        .din_last            (din_last),
        .dout                (dout),
        .valid               (valid),
        .ready               (ready),
        .keep                (keep),
        .last                (last),
        .beat_cnt            (beat_cnt),
        .pkt_cnt             (pkt_cnt)
    );

    ip_stream_packer #(.DIN_W(8)) dut8 (
        .m_axis_mm2s_aclk    (clk),
        .m_axis_mm2s_aresetn (rst_n),
        .din                 (b_din),
        .din_valid           (b_din_valid),
        .din_ready           (b_din_ready),
        .din_last            (b_din_last),
        .dout                (b_dout),
        .valid               (b_valid),
        .ready               (b_ready),
        .keep                (b_keep),
        .last                (b_last),
        .beat_cnt            (b_beat_cnt),
        .pkt_cnt             (b_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: a packet is cut into groups of four words; the last group may be short.
    task automatic gen_packet(input int len, input bit rnd, input logic [31:0] base);
        logic [127:0] d;
        logic [15:0]  k;
        logic [31:0]  w;
        int n;
        n = 0;
        d = '0;
        for (int i = 0; i < len; i++) begin
            w = rnd ? $urandom : base + 32'(i);
            in_q.push_back({(i == len - 1), w});
            d[n*32 +: 32] = w;
            n++;
            if (n == 4 || i == len - 1) begin
                k = '0;
                for (int b = 0; b < n * 4; b++) k[b] = 1'b1;
                exp_q.push_back('{d, k, (i == len - 1)});
                gen_beats++;
                if (i == len - 1) gen_pkts++;
                n = 0;
                d = '0;
            end
        end
    endtask

    task automatic run(input int max_cycles, input int pv, input int pr, input bit until_empty);
        beat_t e;
        cyc = 0;
        while (cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            if (prev_hold) begin
                chk("hold_dout", dout, prev_dout);
                chk("hold_keep", 128'(keep), 128'(prev_keep));
                chk("hold_last", 128'(last), 128'(prev_last));
            end
            if (until_empty && in_q.size() == 0 && exp_q.size() == 0) break;
            din_valid = (in_q.size() > 0) && (int'($urandom_range(99)) < pv);
            {din_last, din} = (in_q.size() > 0) ? in_q[0] : 33'd0;
            ready = (int'($urandom_range(99)) < pr);
            #1;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 128'(valid), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", dout, e.data);
                    chk("beat_keep", 128'(keep), 128'(e.keep));
                    chk("beat_last", 128'(last), 128'(e.last));
                end
            end
            if (din_valid && din_ready) begin
                void'(in_q.pop_front());
                accepted++;
            end
            prev_hold = valid && !ready;
            prev_dout = dout;
            prev_keep = keep;
            prev_last = last;
        end
        if (until_empty)
            chk("drain_timeout", 128'(in_q.size() + exp_q.size()), 128'(0));
        din_valid = 1'b0;
        din_last  = 1'b0;
        ready     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 128'(valid), 128'(0));
        chk({tag, "_dout"}, dout, 128'(0));
        chk({tag, "_keep"}, 128'(keep), 128'(0));
        chk({tag, "_last"}, 128'(last), 128'(0));
        chk({tag, "_beat_cnt"}, 128'(beat_cnt), 128'(0));
        chk({tag, "_pkt_cnt"}, 128'(pkt_cnt), 128'(0));
        chk({tag, "_din_ready"}, 128'(din_ready), 128'(1));
    endtask

    initial begin
        logic [127:0] exp8;
        int len;

        rst_n = 1'b1;
        din = '0; din_valid = 1'b0; din_last = 1'b0; ready = 1'b0;
        b_din = '0; b_din_valid = 1'b0; b_din_last = 1'b0; b_ready = 1'b1;
        prev_hold = 1'b0; prev_dout = '0; prev_keep = '0; prev_last = 1'b0;

        // Reset state
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full beats: eight words, second beat ends the packet
        gen_packet(8, 1'b0, 32'h0);
        run(100, 100, 100, 1'b1);
        chk("full_cycles", 128'(cyc), 128'(10));
        chk("full_beat_cnt", 128'(beat_cnt), 128'(gen_beats));
        chk("full_pkt_cnt", 128'(pkt_cnt), 128'(gen_pkts));

        // Partial flush and single-word packet
        gen_packet(3, 1'b0, 32'hA);
        gen_packet(1, 1'b0, 32'h55);
        run(100, 100, 100, 1'b1);

        // Backpressure: downstream stalled for 20 cycles
        gen_packet(12, 1'b1, 32'h0);
        accepted = 0;
        run(20, 100, 0, 1'b0);
        chk("bp_accepted", 128'(accepted), 128'(8));
        chk("bp_din_ready", 128'(din_ready), 128'(0));
        chk("bp_valid", 128'(valid), 128'(1));
        run(200, 100, 100, 1'b1);
        chk("bp_beat_cnt", 128'(beat_cnt), 128'(gen_beats));

        // Random handshakes, 1000 packets
        for (int p = 0; p < 1000; p++) begin
            len = int'($urandom_range(12, 1));
            gen_packet(len, 1'b1, 32'h0);
        end
        run(60000, 50, 50, 1'b1);
        chk("rand_pkt_cnt", 128'(pkt_cnt), 128'(gen_pkts));
        chk("rand_beat_cnt", 128'(beat_cnt), 128'(gen_beats));

        // Reset mid-packet with a beat held in the output register
        gen_packet(4, 1'b1, 32'h0);
        in_q.push_back({1'b0, 32'hDEAD_0001});
        in_q.push_back({1'b0, 32'hDEAD_0002});
        run(10, 100, 0, 1'b0);
        chk("pre_reset_valid", 128'(valid), 128'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        in_q.delete();
        exp_q.delete();
        gen_beats = 0;
        gen_pkts = 0;
        prev_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gen_packet(4, 1'b1, 32'h0);
        run(50, 100, 100, 1'b1);
        chk("post_reset_beat_cnt", 128'(beat_cnt), 128'(1));
        chk("post_reset_pkt_cnt", 128'(pkt_cnt), 128'(1));

        // DIN_W=8 build: sixteen bytes form one full beat
        exp8 = '0;
        for (int i = 0; i < 16; i++) exp8[i*8 +: 8] = 8'(i);
        @(negedge clk);
        chk("b8_din_ready", 128'(b_din_ready), 128'(1));
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            b_din = 8'(i);
            b_din_valid = 1'b1;
            b_din_last = (i == 15);
        end
        @(negedge clk);
        b_din_valid = 1'b0;
        b_din_last = 1'b0;
        chk("b8_valid", 128'(b_valid), 128'(1));
        chk("b8_dout", b_dout, exp8);
        chk("b8_keep", 128'(b_keep), 128'(16'hFFFF));
        chk("b8_last", 128'(b_last), 128'(1));
        @(negedge clk);
        chk("b8_pkt_cnt", 128'(b_pkt_cnt), 128'(1));
        chk("b8_beat_cnt", 128'(b_beat_cnt), 128'(1));
        chk("b8_valid_clear", 128'(b_valid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
